csb_master_arb: RTL and testbench
=================================

CSB_MASTER_ARB -- requirements
Module: csb_master_arb

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024, SHALL set the response-wait limit in cycles (range 2..65535).
REQ-002 Clock and reset are fixed: one clock; reset is asynchronous and active-high.
REQ-003 pclk  input  1  SHALL be the single clock.
REQ-004 prst  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 mN_valid  input  1  (N=0,1) SHALL indicate a request from master N.
REQ-006 mN_ready  output  1  SHALL indicate that the arbiter accepts the master N request.
REQ-007 mN_addr  input  16  SHALL carry the master N CSB address.
REQ-008 mN_wdat  input  32  SHALL carry the master N write data.
REQ-009 mN_write  input  1  SHALL be 1 for a write and 0 for a read.
REQ-010 mN_nposted  input  1  SHALL mark a non-posted write.
REQ-011 mN_rvalid  output  1  SHALL flag a response to master N.
REQ-012 mN_rdata  output  32  SHALL carry the response data to master N.
REQ-013 csb2nvdla_valid, csb2nvdla_ready, csb2nvdla_addr[15:0], csb2nvdla_wdat[31:0], csb2nvdla_write and csb2nvdla_nposted SHALL form the shared CSB request port: valid, addr, wdat, write and nposted are outputs; ready is an input.
REQ-014 nvdla2csb_valid (input, 1) and nvdla2csb_data (input, 32) SHALL form the shared CSB response port.
REQ-015 arb_timeout  output  1  SHALL be a one-cycle pulse on response timeout.

Function
REQ-016 The FSM SHALL have three states: IDLE, REQ and WAIT_RSP.
- Only one transaction SHALL be outstanding at any time.
REQ-017 Acceptance in IDLE: if any mN_valid is high, grant exactly one master.
- mN_ready for the granted master SHALL be high combinationally in that same cycle.
- addr, wdat, write and nposted SHALL be captured into registers.
- Next state SHALL be REQ.
REQ-018 Round-robin arbitration:
- If both masters are valid, the master not granted last SHALL win.
- If only one master is valid, that master SHALL win.
- The last-grant pointer SHALL update only on acceptance.
REQ-019 In REQ:
- csb2nvdla_valid SHALL be 1, with the payload driven from the registers, held stable until csb2nvdla_ready is high.
- csb2nvdla_valid SHALL first rise 1 cycle after acceptance.
REQ-020 On the csb2nvdla handshake:
- A posted write (write=1, nposted=0) SHALL return to IDLE.
- A read or a non-posted write SHALL go to WAIT_RSP.
REQ-021 In WAIT_RSP, when nvdla2csb_valid is high:
- mN_rvalid of the granted master SHALL equal nvdla2csb_valid, and mN_rdata SHALL equal nvdla2csb_data (zero-latency pass-through).
- Next state SHALL be IDLE.
REQ-022 nvdla2csb_valid outside WAIT_RSP SHALL be ignored: no mN_rvalid is produced.
REQ-023 mN_ready and mN_rvalid of the non-granted master SHALL stay 0.
- mN_rdata SHALL be 0 whenever mN_rvalid is 0.
REQ-024 A new acceptance SHALL occur no earlier than the cycle after the return to IDLE.
- Minimum spacing between posted writes is therefore 3 cycles.

Reset
REQ-025 On prst:
- State SHALL be IDLE, the last-grant pointer SHALL be 1 (so master 0 wins first), and all output registers and the timeout counter SHALL be 0.
- All outputs SHALL be 0 while prst is asserted.
REQ-026 Reset asserted mid-transaction SHALL drop the transaction; no response is delivered after release.

Configuration
REQ-027 With CSB_MASTER_ARB_TIMEOUT_EN defined, the counter SHALL:
- clear on entry to WAIT_RSP and increment each WAIT_RSP cycle.
- on reaching TIMEOUT_CYCLES-1 with no response, pulse arb_timeout and drive mN_rvalid=1 with mN_rdata=32'hDEAD_0BAD to the granted master.
- then return to IDLE.
REQ-028 If the real response and the timeout expiry coincide, the real response SHALL win and arb_timeout SHALL stay 0.
REQ-029 Without CSB_MASTER_ARB_TIMEOUT_EN:
- there SHALL be no counter logic, and WAIT_RSP SHALL wait indefinitely.
- the arb_timeout port SHALL remain and be tied to 0.

Structure
REQ-030 A shared package SHALL hold the FSM state encoding, the CSB address and data width constants and the timeout-data constant 32'hDEAD_0BAD.
REQ-031 A single sub-module csb_rr_arb2 (2-way round-robin grant with pointer) SHALL be instantiated once.

Verification
REQ-032 m0 read addr 0x0040, ready=1 immediately, response 0x12345678 at 3 cycles -> m0_rvalid one cycle with data 0x12345678, m1 silent.
REQ-033 m0 and m1 valid every cycle, posted writes -> grants alternate m0,m1,m0,m1, first grant m0, accept spacing 3 cycles.
REQ-034 m1 non-posted write wdat 0xA5A5A5A5, csb2nvdla_ready low 5 cycles -> payload stable for 5 cycles, m1_rvalid on response, no second accept meanwhile.
REQ-035 (macro on, TIMEOUT_CYCLES=16) read with no response -> arb_timeout and m0_rvalid pulse in the 16th WAIT_RSP cycle with data 0xDEAD0BAD; response arriving in that same cycle -> real data, arb_timeout=0.
REQ-036 prst pulsed in WAIT_RSP, then a late nvdla2csb_valid -> no mN_rvalid, state IDLE, next grant m0.

Source files
------------

// File: rtl/csb_master_arb_pkg.sv
// Shared types and constants for the two-master CSB arbiter.
package csb_master_arb_pkg;

  localparam int unsigned CSB_AW   = 16;
  localparam int unsigned CSB_DW   = 32;
  localparam int unsigned TO_CNT_W = 16;

  localparam logic [CSB_DW-1:0] TIMEOUT_RDATA = 32'hDEAD_0BAD;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [CSB_AW-1:0] addr;
    logic [CSB_DW-1:0] wdat;
    logic              write;
    logic              nposted;
  } csb_req_t;

  // Posted writes complete on the request handshake and expect no response.
  function automatic logic is_posted(csb_req_t r);
    return r.write & ~r.nposted;
  endfunction

endpackage

// File: rtl/csb_master_arb_if.sv
// Bus bundle: two master request/response ports plus the shared CSB port.
interface csb_master_arb_if;
  import csb_master_arb_pkg::*;

  logic              m0_valid;
  logic              m0_ready;
  logic [CSB_AW-1:0] m0_addr;
  logic [CSB_DW-1:0] m0_wdat;
  logic              m0_write;
  logic              m0_nposted;
  logic              m0_rvalid;
  logic [CSB_DW-1:0] m0_rdata;

  logic              m1_valid;
  logic              m1_ready;
  logic [CSB_AW-1:0] m1_addr;
  logic [CSB_DW-1:0] m1_wdat;
  logic              m1_write;
  logic              m1_nposted;
  logic              m1_rvalid;
  logic [CSB_DW-1:0] m1_rdata;

  logic              csb2nvdla_valid;
  logic              csb2nvdla_ready;
  logic [CSB_AW-1:0] csb2nvdla_addr;
  logic [CSB_DW-1:0] csb2nvdla_wdat;
  logic              csb2nvdla_write;
  logic              csb2nvdla_nposted;

  logic              nvdla2csb_valid;
  logic [CSB_DW-1:0] nvdla2csb_data;

  logic              arb_timeout;

  // Arbiter side.
  modport slave (
    input  m0_valid, m0_addr, m0_wdat, m0_write, m0_nposted,
    output m0_ready, m0_rvalid, m0_rdata,
    input  m1_valid, m1_addr, m1_wdat, m1_write, m1_nposted,
    output m1_ready, m1_rvalid, m1_rdata,
    output csb2nvdla_valid, csb2nvdla_addr, csb2nvdla_wdat, csb2nvdla_write, csb2nvdla_nposted,
    input  csb2nvdla_ready,
    input  nvdla2csb_valid, nvdla2csb_data,
    output arb_timeout
  );

  // Environment side (masters and CSB target).
  modport master (
    output m0_valid, m0_addr, m0_wdat, m0_write, m0_nposted,
    input  m0_ready, m0_rvalid, m0_rdata,
    output m1_valid, m1_addr, m1_wdat, m1_write, m1_nposted,
    input  m1_ready, m1_rvalid, m1_rdata,
    input  csb2nvdla_valid, csb2nvdla_addr, csb2nvdla_wdat, csb2nvdla_write, csb2nvdla_nposted,
    output csb2nvdla_ready,
    output nvdla2csb_valid, nvdla2csb_data,
    input  arb_timeout
  );

endinterface

// File: rtl/csb_master_arb_rr_arb2.sv
// Two-way round-robin grant; pointer holds the last granted index.
module csb_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic [1:0] gnt_c_o,
  output logic       gnt_idx_c_o
);

  logic last_q, last_d;

  always_comb begin
    gnt_c_o     = 2'b00;
    gnt_idx_c_o = 1'b0;
    if (req_i == 2'b11) begin
      gnt_idx_c_o = ~last_q;
    end else begin
      gnt_idx_c_o = req_i[1];
    end
    if (req_i != 2'b00) begin
      gnt_c_o = gnt_idx_c_o ? 2'b10 : 2'b01;
    end
    last_d = accept_i ? gnt_idx_c_o : last_q;
  end

  // Reset to 1 so master 0 wins the first contested grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/csb_master_arb.sv
// Two-master CSB arbiter, one outstanding transaction.
// Optional response timeout enabled by CSB_MASTER_ARB_TIMEOUT_EN.
module csb_master_arb
  import csb_master_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input logic             pclk,
  input logic             prst,
  csb_master_arb_if.slave bus
);

  arb_state_e state_q, state_d;
  csb_req_t   req_q, req_d;
  csb_req_t   m0_req_c, m1_req_c;
  logic       owner_q, owner_d;
  logic       hold_q, hold_d;
  logic [1:0] gnt_c;
  logic       gnt_idx_c;
  logic       accept_c;
  logic       rsp_c;
  logic       timeout_c;
  logic       rvalid_c;
  logic [CSB_DW-1:0] rdata_c;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("csb_master_arb: TIMEOUT_CYCLES must be in 2..65535");
  end

  assign m0_req_c = '{addr: bus.m0_addr, wdat: bus.m0_wdat,
                      write: bus.m0_write, nposted: bus.m0_nposted};
  assign m1_req_c = '{addr: bus.m1_addr, wdat: bus.m1_wdat,
                      write: bus.m1_write, nposted: bus.m1_nposted};

  // hold_q blocks acceptance in the first IDLE cycle after a transaction ends.
  assign accept_c = !prst && (state_q == IDLE) && !hold_q && (bus.m0_valid || bus.m1_valid);
  assign rsp_c    = (state_q == WAIT_RSP) && bus.nvdla2csb_valid;

  csb_rr_arb2 u_rr (
    .clk        (pclk),
    .rst        (prst),
    .req_i      ({bus.m1_valid, bus.m0_valid}),
    .accept_i   (accept_c),
    .gnt_c_o    (gnt_c),
    .gnt_idx_c_o(gnt_idx_c)
  );

`ifdef CSB_MASTER_ARB_TIMEOUT_EN
  localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [TO_CNT_W-1:0] to_cnt_q, to_cnt_d;

  // Counter sits at zero outside WAIT_RSP, so it starts cleared on entry.
  assign to_cnt_d  = (state_q == WAIT_RSP) ? to_cnt_q + TO_CNT_W'(1) : '0;
  assign timeout_c = (state_q == WAIT_RSP) && !bus.nvdla2csb_valid && (to_cnt_q == TO_LAST);

  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  assign timeout_c = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    owner_d = owner_q;
    unique case (state_q)
      IDLE: begin
        if (accept_c) begin
          state_d = REQ;
          owner_d = gnt_idx_c;
          req_d   = gnt_idx_c ? m1_req_c : m0_req_c;
        end
      end
      REQ: begin
        if (bus.csb2nvdla_ready) begin
          state_d = is_posted(req_q) ? IDLE : WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        if (rsp_c || timeout_c) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    hold_d = (state_q != IDLE) && (state_d == IDLE);
  end

  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      state_q <= IDLE;
      req_q   <= '0;
      owner_q <= 1'b0;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      owner_q <= owner_d;
      hold_q  <= hold_d;
    end
  end

  // Real response takes priority over the timeout filler data.
  always_comb begin
    rvalid_c = rsp_c || timeout_c;
    rdata_c  = '0;
    if (rsp_c) begin
      rdata_c = bus.nvdla2csb_data;
    end else if (timeout_c) begin
      rdata_c = TIMEOUT_RDATA;
    end

    bus.m0_ready  = accept_c && gnt_c[0];
    bus.m1_ready  = accept_c && gnt_c[1];
    bus.m0_rvalid = rvalid_c && !owner_q;
    bus.m1_rvalid = rvalid_c && owner_q;
    bus.m0_rdata  = bus.m0_rvalid ? rdata_c : '0;
    bus.m1_rdata  = bus.m1_rvalid ? rdata_c : '0;

    bus.csb2nvdla_valid   = (state_q == REQ);
    bus.csb2nvdla_addr    = req_q.addr;
    bus.csb2nvdla_wdat    = req_q.wdat;
    bus.csb2nvdla_write   = req_q.write;
    bus.csb2nvdla_nposted = req_q.nposted;
    bus.arb_timeout       = timeout_c;
  end

endmodule

// File: tb/tb_csb_master_arb.sv
// Directed self-checking bench for csb_master_arb (TIMEOUT_CYCLES=16).
// Timeout scenario runs when CSB_MASTER_ARB_TIMEOUT_EN is defined.
module tb_csb_master_arb;

  logic pclk = 1'b0;
  logic prst;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  csb_master_arb_if bus ();

  csb_master_arb #(.TIMEOUT_CYCLES(16)) dut (
    .pclk(pclk),
    .prst(prst),
    .bus (bus)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Inputs change 2 time units after the rising edge; checks follow 1 unit later.
  task automatic step();
    @(posedge pclk);
    #2;
  endtask

  task automatic clear_inputs();
    bus.m0_valid = 1'b0; bus.m0_addr = '0; bus.m0_wdat = '0; bus.m0_write = 1'b0; bus.m0_nposted = 1'b0;
    bus.m1_valid = 1'b0; bus.m1_addr = '0; bus.m1_wdat = '0; bus.m1_write = 1'b0; bus.m1_nposted = 1'b0;
    bus.csb2nvdla_ready = 1'b0;
    bus.nvdla2csb_valid = 1'b0;
    bus.nvdla2csb_data  = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    prst = 1'b1;
    step();
    prst = 1'b0;
  endtask

  initial begin
    clear_inputs();
    prst = 1'b1;
    bus.m0_valid = 1'b1;
    #1;
    chk("rst_ready", 32'({bus.m0_ready, bus.m1_ready}), 32'h0);
    chk("rst_csb_valid", 32'(bus.csb2nvdla_valid), 32'h0);
    step();
    chk("rst_csb_addr", 32'(bus.csb2nvdla_addr), 32'h0);
    chk("rst_timeout", 32'(bus.arb_timeout), 32'h0);
    prst = 1'b0;
    bus.m0_valid = 1'b0;

    // m0 read of 0x0040, immediate ready, response three cycles after accept
    step();
    bus.m0_valid = 1'b1; bus.m0_addr = 16'h0040; bus.m0_write = 1'b0;
    #1;
    chk("t1_acc_ready", 32'({bus.m0_ready, bus.m1_ready}), 32'h2);
    chk("t1_acc_csbv", 32'(bus.csb2nvdla_valid), 32'h0);
    step();
    bus.m0_valid = 1'b0; bus.csb2nvdla_ready = 1'b1;
    #1;
    chk("t1_req_valid", 32'(bus.csb2nvdla_valid), 32'h1);
    chk("t1_req_addr", 32'(bus.csb2nvdla_addr), 32'h0040);
    chk("t1_req_write", 32'(bus.csb2nvdla_write), 32'h0);
    step();
    bus.csb2nvdla_ready = 1'b0;
    #1;
    chk("t1_wait_csbv", 32'(bus.csb2nvdla_valid), 32'h0);
    chk("t1_wait_rv", 32'({bus.m0_rvalid, bus.m1_rvalid}), 32'h0);
    step();
    bus.nvdla2csb_valid = 1'b1; bus.nvdla2csb_data = 32'h1234_5678;
    #1;
    chk("t1_rsp_rv", 32'({bus.m0_rvalid, bus.m1_rvalid}), 32'h2);
    chk("t1_rsp_m0_data", bus.m0_rdata, 32'h1234_5678);
    chk("t1_rsp_m1_data", bus.m1_rdata, 32'h0);
    chk("t1_rsp_timeout", 32'(bus.arb_timeout), 32'h0);
    step();
    #1;
    chk("t1_ignored_rv", 32'({bus.m0_rvalid, bus.m1_rvalid}), 32'h0);
    chk("t1_ignored_data", bus.m0_rdata, 32'h0);

    // Both masters stream posted writes: alternate grants every 3 cycles
    do_reset();
    bus.m0_valid = 1'b1; bus.m0_write = 1'b1; bus.m0_nposted = 1'b0; bus.m0_wdat = 32'h1111_0000;
    bus.m1_valid = 1'b1; bus.m1_write = 1'b1; bus.m1_nposted = 1'b0; bus.m1_wdat = 32'h2222_0000;
    bus.csb2nvdla_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      int slot;
      int phase;
      slot  = c / 3;
      phase = c % 3;
      #1;
      chk($sformatf("t2_ready_c%0d", c), 32'({bus.m0_ready, bus.m1_ready}),
          (phase == 0) ? ((slot % 2 == 0) ? 32'h2 : 32'h1) : 32'h0);
      chk($sformatf("t2_csbv_c%0d", c), 32'(bus.csb2nvdla_valid), (phase == 1) ? 32'h1 : 32'h0);
      if (phase == 1) begin
        chk($sformatf("t2_wdat_c%0d", c), bus.csb2nvdla_wdat,
            (slot % 2 == 0) ? 32'h1111_0000 : 32'h2222_0000);
      end
      step();
    end
    bus.m0_valid = 1'b0; bus.m1_valid = 1'b0; bus.csb2nvdla_ready = 1'b0;

    // m1 non-posted write held 5 cycles by the target; m0 waits behind it
    bus.m1_valid = 1'b1; bus.m1_addr = 16'h0123; bus.m1_wdat = 32'hA5A5_A5A5;
    bus.m1_write = 1'b1; bus.m1_nposted = 1'b1;
    #1;
    chk("t3_acc_ready", 32'({bus.m0_ready, bus.m1_ready}), 32'h1);
    step();
    bus.m1_valid = 1'b0;
    bus.m0_valid = 1'b1; bus.m0_addr = 16'h0200; bus.m0_write = 1'b0; bus.m0_nposted = 1'b0;
    bus.m0_wdat = 32'h0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("t3_stall_valid_%0d", k), 32'(bus.csb2nvdla_valid), 32'h1);
      chk($sformatf("t3_stall_addr_%0d", k), 32'(bus.csb2nvdla_addr), 32'h0123);
      chk($sformatf("t3_stall_wdat_%0d", k), bus.csb2nvdla_wdat, 32'hA5A5_A5A5);
      chk($sformatf("t3_stall_wr_np_%0d", k), 32'({bus.csb2nvdla_write, bus.csb2nvdla_nposted}), 32'h3);
      chk($sformatf("t3_stall_ready_%0d", k), 32'({bus.m0_ready, bus.m1_ready}), 32'h0);
      step();
    end
    bus.csb2nvdla_ready = 1'b1;
    #1;
    chk("t3_hs_valid", 32'(bus.csb2nvdla_valid), 32'h1);
    step();
    bus.csb2nvdla_ready = 1'b0;
    #1;
    chk("t3_wait_csbv", 32'(bus.csb2nvdla_valid), 32'h0);
    chk("t3_wait_ready", 32'({bus.m0_ready, bus.m1_ready}), 32'h0);
    step();
    bus.nvdla2csb_valid = 1'b1; bus.nvdla2csb_data = 32'hCAFE_F00D;
    #1;
    chk("t3_rsp_rv", 32'({bus.m0_rvalid, bus.m1_rvalid}), 32'h1);
    chk("t3_rsp_m1_data", bus.m1_rdata, 32'hCAFE_F00D);
    chk("t3_rsp_m0_data", bus.m0_rdata, 32'h0);
    chk("t3_rsp_ready", 32'({bus.m0_ready, bus.m1_ready}), 32'h0);
    step();
    bus.nvdla2csb_valid = 1'b0;
    #1;
    chk("t3_hold_ready", 32'({bus.m0_ready, bus.m1_ready}), 32'h0);
    step();
    #1;
    chk("t3_next_ready", 32'({bus.m0_ready, bus.m1_ready}), 32'h2);

    // Reset during WAIT_RSP drops the m0 read; late response is ignored
    step();
    bus.m0_valid = 1'b0; bus.csb2nvdla_ready = 1'b1;
    #1;
    chk("t4_req_addr", 32'(bus.csb2nvdla_addr), 32'h0200);
    step();
    bus.csb2nvdla_ready = 1'b0;
    #1;
    chk("t4_wait_csbv", 32'(bus.csb2nvdla_valid), 32'h0);
    prst = 1'b1;
    #1;
    chk("t4_rst_rv", 32'({bus.m0_rvalid, bus.m1_rvalid}), 32'h0);
    chk("t4_rst_addr", 32'(bus.csb2nvdla_addr), 32'h0);
    step();
    prst = 1'b0;
    bus.nvdla2csb_valid = 1'b1; bus.nvdla2csb_data = 32'h0000_0099;
    #1;
    chk("t4_late_rv", 32'({bus.m0_rvalid, bus.m1_rvalid}), 32'h0);
    chk("t4_late_data", bus.m0_rdata, 32'h0);
    step();
    bus.nvdla2csb_valid = 1'b0;
    bus.m0_valid = 1'b1; bus.m1_valid = 1'b1;
    #1;
    chk("t4_regrant", 32'({bus.m0_ready, bus.m1_ready}), 32'h2);
    chk("t4_idle_csbv", 32'(bus.csb2nvdla_valid), 32'h0);

`ifdef CSB_MASTER_ARB_TIMEOUT_EN
    // Pass 0: no response -> timeout filler; pass 1: response on the expiry cycle wins
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      bus.m0_valid = 1'b1; bus.m0_addr = 16'h0300; bus.m0_write = 1'b0;
      #1;
      chk($sformatf("t5_acc_p%0d", pass), 32'({bus.m0_ready, bus.m1_ready}), 32'h2);
      step();
      bus.m0_valid = 1'b0; bus.csb2nvdla_ready = 1'b1;
      step();
      bus.csb2nvdla_ready = 1'b0;
      for (int w = 1; w < 16; w++) begin
        #1;
        chk($sformatf("t5_wait_to_p%0d_w%0d", pass, w),
            32'({bus.arb_timeout, bus.m0_rvalid, bus.m1_rvalid}), 32'h0);
        step();
      end
      if (pass == 1) begin
        bus.nvdla2csb_valid = 1'b1; bus.nvdla2csb_data = 32'h5555_AAAA;
      end
      #1;
      chk($sformatf("t5_expiry_to_p%0d", pass), 32'(bus.arb_timeout), (pass == 0) ? 32'h1 : 32'h0);
      chk($sformatf("t5_expiry_rv_p%0d", pass), 32'({bus.m0_rvalid, bus.m1_rvalid}), 32'h2);
      chk($sformatf("t5_expiry_data_p%0d", pass), bus.m0_rdata,
          (pass == 0) ? 32'hDEAD_0BAD : 32'h5555_AAAA);
      step();
      bus.nvdla2csb_valid = 1'b0;
      #1;
      chk($sformatf("t5_after_p%0d", pass),
          32'({bus.arb_timeout, bus.m0_rvalid, bus.csb2nvdla_valid}), 32'h0);
    end
`else
    // No timeout hardware: WAIT_RSP holds well past 16 cycles
    do_reset();
    bus.m0_valid = 1'b1; bus.m0_addr = 16'h0300; bus.m0_write = 1'b0;
    #1;
    chk("t5_acc", 32'({bus.m0_ready, bus.m1_ready}), 32'h2);
    step();
    bus.m0_valid = 1'b0; bus.csb2nvdla_ready = 1'b1;
    step();
    bus.csb2nvdla_ready = 1'b0;
    for (int w = 1; w <= 40; w++) begin
      #1;
      if (w % 10 == 0) begin
        chk($sformatf("t5_nowait_w%0d", w),
            32'({bus.arb_timeout, bus.m0_rvalid, bus.m1_rvalid}), 32'h0);
      end
      step();
    end
    bus.nvdla2csb_valid = 1'b1; bus.nvdla2csb_data = 32'h0BAD_F00D;
    #1;
    chk("t5_late_rsp_rv", 32'({bus.m0_rvalid, bus.m1_rvalid}), 32'h2);
    chk("t5_late_rsp_data", bus.m0_rdata, 32'h0BAD_F00D);
    step();
    bus.nvdla2csb_valid = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
